// File: rtl/level_gen_seq.sv
// Sequenced H/L level generator: outputs hold safe levels through a settle window, then drive
// masked-writable run levels. Optional parity output enabled by LEVEL_GEN_PARITY_EN.
module level_gen_seq #(
    parameter int                    CHANNELS      = 8,
    parameter int                    SETTLE_CYCLES = 16,
    parameter logic [CHANNELS-1:0]   SAFE_LEVELS   = {CHANNELS{1'b0}},
    parameter logic [CHANNELS-1:0]   ACTIVE_LEVELS = {CHANNELS{1'b1}}
) (
    input  logic                sysclk,
    input  logic                sys_rst,
    input  logic                safe_req,
    input  logic                reload,
    input  logic                wr_en,
    output logic                wr_rdy,
    input  logic [CHANNELS-1:0] wr_mask,
    input  logic [CHANNELS-1:0] wr_data,
    output logic [CHANNELS-1:0] lvl_out,
    output logic                settled
`ifdef LEVEL_GEN_PARITY_EN
    ,
    output logic                lvl_par
`endif
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_SAFE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CHANNELS-1:0] lvl_reg_q, lvl_reg_d;
    logic [CHANNELS-1:0] lvl_out_q, lvl_out_d;
    logic                settled_q, settled_d;

`ifdef LEVEL_GEN_PARITY_EN
    logic                lvl_par_q, lvl_par_d;

    function automatic logic parity_f(input logic [CHANNELS-1:0] v);
        return ^v;
    endfunction
`endif

    assign wr_rdy  = (state_q == ST_RUN);
    assign lvl_out = lvl_out_q;
    assign settled = settled_q;
`ifdef LEVEL_GEN_PARITY_EN
    assign lvl_par = lvl_par_q;
`endif

    // Next-state, level register update and registered-output preview
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_reg_d = lvl_reg_q;

        // reload wins over a same-cycle write; writes outside RUN are dropped
        if (reload) begin
            lvl_reg_d = ACTIVE_LEVELS;
        end else if (wr_en && wr_rdy) begin
            lvl_reg_d = (lvl_reg_q & ~wr_mask) | (wr_data & wr_mask);
        end else begin
            lvl_reg_d = lvl_reg_q;
        end

        if (safe_req) begin
            state_d = ST_SAFE;
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                    cnt_d   = {CW{1'b0}};
                end
                ST_SAFE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = {CW{1'b0}};
                end
                default: begin
                    state_d = ST_SETTLE;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end

        // Outputs follow the state being entered on this edge
        if (state_d == ST_RUN) begin
            lvl_out_d = lvl_reg_d;
            settled_d = 1'b1;
        end else begin
            lvl_out_d = SAFE_LEVELS;
            settled_d = 1'b0;
        end
`ifdef LEVEL_GEN_PARITY_EN
        lvl_par_d = parity_f(lvl_out_d);
`endif
    end

    // State, counter, level register and output registers
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= {CW{1'b0}};
            lvl_reg_q <= ACTIVE_LEVELS;
            lvl_out_q <= SAFE_LEVELS;
            settled_q <= 1'b0;
`ifdef LEVEL_GEN_PARITY_EN
            lvl_par_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_reg_q <= lvl_reg_d;
            lvl_out_q <= lvl_out_d;
            settled_q <= settled_d;
`ifdef LEVEL_GEN_PARITY_EN
            lvl_par_q <= lvl_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_level_gen_seq.sv
// Directed bench for level_gen_seq (CHANNELS=8, SETTLE_CYCLES=4, SAFE=8'h00, ACTIVE=8'hA5).
// Define LEVEL_GEN_PARITY_EN to also check lvl_par every cycle.
module tb_level_gen_seq;

    logic       sysclk;
    logic       sys_rst;
    logic       safe_req;
    logic       reload;
    logic       wr_en;
    logic       wr_rdy;
    logic [7:0] wr_mask;
    logic [7:0] wr_data;
    logic [7:0] lvl_out;
    logic       settled;
`ifdef LEVEL_GEN_PARITY_EN
    logic       lvl_par;
`endif

    int tests_s;
    int fails_s;
    logic [9:0] obs_s;

    level_gen_seq #(
        .CHANNELS      (8),
        .SETTLE_CYCLES (4),
        .SAFE_LEVELS   (8'h00),
        .ACTIVE_LEVELS (8'hA5)
    ) dut (
        .sysclk   (sysclk),
        .sys_rst  (sys_rst),
        .safe_req (safe_req),
        .reload   (reload),
        .wr_en    (wr_en),
        .wr_rdy   (wr_rdy),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .lvl_out  (lvl_out),
        .settled  (settled)
`ifdef LEVEL_GEN_PARITY_EN
        ,
        .lvl_par  (lvl_par)
`endif
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    assign obs_s = {lvl_out, settled, wr_rdy};

`ifdef LEVEL_GEN_PARITY_EN
    logic par_on_s = 1'b0;
    // lvl_par must match the XOR of lvl_out on every cycle
    always @(negedge sysclk) begin
        if (par_on_s) begin
            tests_s++;
            if (lvl_par !== ^lvl_out) begin
                fails_s++;
                $display("FAIL parity lvl_out=%h lvl_par=%b exp=%b", lvl_out, lvl_par, ^lvl_out);
            end
        end
    end
`endif

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; safe_req = 1'b0; reload = 1'b0; wr_en = 1'b0;
        wr_mask = 8'h00; wr_data = 8'h00;
        tick(); tick();
`ifdef LEVEL_GEN_PARITY_EN
        par_on_s = 1'b1;
`endif
        tests_s++;
        if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
            fails_s++; $display("FAIL reset_state got=%h exp=%h", obs_s, {8'h00, 1'b0, 1'b0});
        end
        sys_rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_s++;
            if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
                fails_s++; $display("FAIL settle_hold[%0d] got=%h exp=%h", i, obs_s, {8'h00, 1'b0, 1'b0});
            end
        end
        tick();
        tests_s++;
        if (obs_s !== {8'hA5, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL run_entry got=%h exp=%h", obs_s, {8'hA5, 1'b1, 1'b1});
        end
    endtask

    task automatic test_settle_drop();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        wr_en = 1'b1; wr_mask = 8'hFF; wr_data = 8'hFF;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_s++;
            if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
                fails_s++; $display("FAIL settle_wr_drop[%0d] got=%h exp=%h", i, obs_s, {8'h00, 1'b0, 1'b0});
            end
        end
        wr_en = 1'b0;
        tick();
        tests_s++;
        if (obs_s !== {8'hA5, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL settle_drop_run got=%h exp=%h", obs_s, {8'hA5, 1'b1, 1'b1});
        end
    endtask

    task automatic test_write();
        wr_en = 1'b1; wr_mask = 8'h0F; wr_data = 8'h3C;
        tick();
        tests_s++;
        if (obs_s !== {8'hAC, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL masked_write got=%h exp=%h", obs_s, {8'hAC, 1'b1, 1'b1});
        end
        wr_mask = 8'h00; wr_data = 8'hFF;
        tick();
        tests_s++;
        if (obs_s !== {8'hAC, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL zero_mask_write got=%h exp=%h", obs_s, {8'hAC, 1'b1, 1'b1});
        end
        wr_en = 1'b0;
    endtask

    task automatic test_safe();
        safe_req = 1'b1; wr_en = 1'b1; wr_mask = 8'hF0; wr_data = 8'h10;
        tick();
        wr_en = 1'b0;
        tests_s++;
        if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
            fails_s++; $display("FAIL safe_entry got=%h exp=%h", obs_s, {8'h00, 1'b0, 1'b0});
        end
        tick(); tick();
        safe_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_s++;
            if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
                fails_s++; $display("FAIL safe_resettle[%0d] got=%h exp=%h", i, obs_s, {8'h00, 1'b0, 1'b0});
            end
        end
        tick();
        tests_s++;
        if (obs_s !== {8'h1C, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL safe_write_commit got=%h exp=%h", obs_s, {8'h1C, 1'b1, 1'b1});
        end
    endtask

    task automatic test_reload_reset();
        reload = 1'b1; wr_en = 1'b1; wr_mask = 8'hFF; wr_data = 8'h00;
        tick();
        reload = 1'b0;
        tests_s++;
        if (obs_s !== {8'hA5, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL reload_over_write got=%h exp=%h", obs_s, {8'hA5, 1'b1, 1'b1});
        end
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        tests_s++;
        if (obs_s !== {8'h5A, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL full_write got=%h exp=%h", obs_s, {8'h5A, 1'b1, 1'b1});
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tests_s++;
        if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
            fails_s++; $display("FAIL midrun_reset got=%h exp=%h", obs_s, {8'h00, 1'b0, 1'b0});
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_s++;
            if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
                fails_s++; $display("FAIL reset_resettle[%0d] got=%h exp=%h", i, obs_s, {8'h00, 1'b0, 1'b0});
            end
        end
        tick();
        tests_s++;
        if (obs_s !== {8'hA5, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL reset_lvl_reg got=%h exp=%h", obs_s, {8'hA5, 1'b1, 1'b1});
        end
    endtask

    task automatic test_safe_priority();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick(); tick(); tick();
        safe_req = 1'b1;
        tick();
        safe_req = 1'b0;
        tests_s++;
        if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
            fails_s++; $display("FAIL safe_over_run got=%h exp=%h", obs_s, {8'h00, 1'b0, 1'b0});
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
        end
        tests_s++;
        if (obs_s !== {8'h00, 1'b0, 1'b0}) begin
            fails_s++; $display("FAIL prio_resettle got=%h exp=%h", obs_s, {8'h00, 1'b0, 1'b0});
        end
        tick();
        tests_s++;
        if (obs_s !== {8'hA5, 1'b1, 1'b1}) begin
            fails_s++; $display("FAIL prio_run got=%h exp=%h", obs_s, {8'hA5, 1'b1, 1'b1});
        end
    endtask

    initial begin
        tests_s = 0;
        fails_s = 0;
        test_reset();
        test_settle_drop();
        test_write();
        test_safe();
        test_reload_reset();
        test_safe_priority();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_s, fails_s);
        $finish;
    end

endmodule
